// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file: address-width helper,
// default geometry and the writeback request struct.
package rf_pkg;

    localparam int RF_DATA_W_DEF = 32;
    localparam int RF_DEPTH_DEF  = 32;

    function automatic int rf_aw(input int depth);
        return $clog2(depth);
    endfunction

    localparam int RF_AW_DEF = rf_aw(RF_DEPTH_DEF);

    typedef struct packed {
        logic                     we;
        logic [RF_AW_DEF-1:0]     addr;
        logic [RF_DATA_W_DEF-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy vector: writes clear, issue sets (issue wins on collision).
// Exposes the current busy bit of each read port's address combinationally.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DEPTH    = RF_DEPTH_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_aw(DEPTH)
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 we0,
    input  logic [AW-1:0]        wr0,
    input  logic                 we1,
    input  logic [AW-1:0]        wr1,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (we0) busy_d[wr0] = 1'b0;
        if (we1) busy_d[wr1] = 1'b0;
        // A freshly issued producer supersedes any result retiring this cycle.
        if (issue_en && !(ZERO_REG != 0 && issue_addr == '0)) busy_d[issue_addr] = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (srst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_lookup
        assign rd_busy[gi] = busy_q[rd_addr[gi*AW +: AW]];
    end

endmodule

// File: rtl/rf_multiport.sv
// Register file with NUM_RD registered read ports, two prioritised write ports
// and a busy scoreboard. Define RF_BYPASS_EN for write-first same-cycle reads.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int DEPTH    = RF_DEPTH_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_aw(DEPTH)
) (
    input  logic                     cpu_clk,
    input  logic                     cpu_rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [AW-1:0]            wR0,
    input  logic [DATA_W-1:0]        wD0,
    input  logic                     we1,
    input  logic [AW-1:0]            wR1,
    input  logic [DATA_W-1:0]        wD1,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_addr
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [NUM_RD-1:0] sb_busy;

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (cpu_clk),
        .srst       (cpu_rst),
        .we0        (we0),
        .wr0        (wR0),
        .we1        (we1),
        .wr1        (wR1),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .rd_addr    (rd_addr),
        .rd_busy    (sb_busy)
    );

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
        if (we0 && !(ZERO_REG != 0 && wR0 == '0)) regs_d[wR0] = wD0;
        if (we1 && !(ZERO_REG != 0 && wR1 == '0)) regs_d[wR1] = wD1;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data_d;
        logic [DATA_W-1:0] data_q;
        logic              busy_d;
        logic              busy_q;

        assign addr = rd_addr[gi*AW +: AW];

        always_comb begin
            data_d = data_q;
            busy_d = busy_q;
            if (rd_en[gi]) begin
                data_d = regs_q[addr];
                busy_d = sb_busy[gi];
`ifdef RF_BYPASS_EN
                if (we0 && wR0 == addr) begin
                    data_d = wD0;
                    busy_d = 1'b0;
                end
                if (we1 && wR1 == addr) begin
                    data_d = wD1;
                    busy_d = 1'b0;
                end
`endif
                // Register 0 must stay zero even when a bypassed write targets it.
                if (ZERO_REG != 0 && addr == '0) begin
                    data_d = '0;
                    busy_d = 1'b0;
                end
            end
        end

        always_ff @(posedge cpu_clk) begin
            if (cpu_rst) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else begin
                data_q <= data_d;
                busy_q <= busy_d;
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = data_q;
        assign rd_busy[gi]                  = busy_q;
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport (default geometry: 32x32, two read ports).
// Expectations for same-cycle read/write follow RF_BYPASS_EN when defined.
module tb_rf_multiport;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we0, we1, issue_en;
    logic [4:0]  wR0, wR1, issue_addr;
    logic [31:0] wD0, wD1;

    int total = 0;
    int bad   = 0;

    rf_multiport dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .we0        (we0),
        .wR0        (wR0),
        .wD0        (wD0),
        .we1        (we1),
        .wR1        (wR1),
        .wD1        (wD1),
        .issue_en   (issue_en),
        .issue_addr (issue_addr)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic step();
        @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; issue_en = 0; rd_en = 2'b00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("chk %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    logic [31:0] exp_byp_data;
    logic [31:0] exp_byp_busy;
    logic [31:0] exp_pri_data;

    initial begin
        cpu_rst = 1; rd_addr = '0; wR0 = '0; wR1 = '0; wD0 = '0; wD1 = '0; issue_addr = '0;
        idle();
        @(negedge cpu_clk);
        step(); step();
        cpu_rst = 0;
        chk("rst_data", rd_data[31:0] | rd_data[63:32], 32'h0);
        chk("rst_busy", {30'b0, rd_busy}, 32'h0);

        // every register reads back zero and idle after reset
        for (int a = 0; a < 32; a++) begin
            rd_en = 2'b11; rd_addr = {a[4:0], a[4:0]};
            step();
            chk("rst_rd0", rd_data[31:0], 32'h0);
            chk("rst_rd1", rd_data[63:32], 32'h0);
            chk("rst_rdbusy", {30'b0, rd_busy}, 32'h0);
        end
        idle();

        // basic write port 0, read port 1
        we0 = 1; wR0 = 5'd5; wD0 = 32'hDEADBEEF;
        step(); idle();
        rd_en = 2'b10; rd_addr = {5'd5, 5'd0};
        step(); idle();
        chk("basic_rd1", rd_data[63:32], 32'hDEADBEEF);

        // read enable low holds previous data
        rd_addr = {5'd0, 5'd0};
        step();
        chk("hold_rd1", rd_data[63:32], 32'hDEADBEEF);

        // write collision: port 1 wins
        we0 = 1; wR0 = 5'd7; wD0 = 32'h11;
        we1 = 1; wR1 = 5'd7; wD1 = 32'h22;
        step(); idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
        step(); idle();
        chk("collide", rd_data[31:0], 32'h22);

        // zero register: write and issue to r0 are dropped
        we0 = 1; wR0 = 5'd0; wD0 = 32'hFFFFFFFF; issue_en = 1; issue_addr = 5'd0;
        step(); idle();
        rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
        step(); idle();
        chk("zero_rd0", rd_data[31:0], 32'h0);
        chk("zero_busy", {30'b0, rd_busy}, 32'h0);
        // zero register under a same-cycle write
        we1 = 1; wR1 = 5'd0; wD1 = 32'hFFFFFFFF; rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
        step(); idle();
        chk("zero_byp", rd_data[31:0], 32'h0);

        // scoreboard: issue sets busy
        issue_en = 1; issue_addr = 5'd3;
        step(); idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        step(); idle();
        chk("sb_issue", {31'b0, rd_busy[0]}, 32'h1);
        // write clears busy
        we0 = 1; wR0 = 5'd3; wD0 = 32'h5;
        step(); idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        step(); idle();
        chk("sb_wr_data", rd_data[31:0], 32'h5);
        chk("sb_wr_busy", {31'b0, rd_busy[0]}, 32'h0);
        // issue and write same cycle: set wins
        we0 = 1; wR0 = 5'd3; wD0 = 32'h6; issue_en = 1; issue_addr = 5'd3;
        step(); idle();
        rd_en = 2'b10; rd_addr = {5'd3, 5'd0};
        step(); idle();
        chk("sb_set_wins", {31'b0, rd_busy[1]}, 32'h1);
        chk("sb_set_data", rd_data[63:32], 32'h6);

        // same-cycle issue and read returns pre-issue busy
        issue_en = 1; issue_addr = 5'd10; rd_en = 2'b01; rd_addr = {5'd0, 5'd10};
        step(); idle();
        chk("iss_rd_pre", {31'b0, rd_busy[0]}, 32'h0);
        rd_en = 2'b01; rd_addr = {5'd0, 5'd10};
        step(); idle();
        chk("iss_rd_post", {31'b0, rd_busy[0]}, 32'h1);

        // bypass: r9 = 1 and busy, then write A5A5A5A5 while reading
        we0 = 1; wR0 = 5'd9; wD0 = 32'h1; issue_en = 1; issue_addr = 5'd9;
        step(); idle();
`ifdef RF_BYPASS_EN
        exp_byp_data = 32'hA5A5A5A5; exp_byp_busy = 32'h0; exp_pri_data = 32'h33;
`else
        exp_byp_data = 32'h1;        exp_byp_busy = 32'h1; exp_pri_data = 32'h0;
`endif
        we0 = 1; wR0 = 5'd9; wD0 = 32'hA5A5A5A5; rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
        step(); idle();
        chk("byp_data", rd_data[63:32], exp_byp_data);
        chk("byp_busy", {31'b0, rd_busy[1]}, exp_byp_busy);
        rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
        step(); idle();
        chk("byp_after", rd_data[63:32], 32'hA5A5A5A5);
        chk("byp_aft_busy", {31'b0, rd_busy[1]}, 32'h0);

        // bypass priority: port 1 over port 0 on r11 (old value 0)
        we0 = 1; wR0 = 5'd11; wD0 = 32'h44; we1 = 1; wR1 = 5'd11; wD1 = 32'h33;
        rd_en = 2'b11; rd_addr = {5'd11, 5'd11};
        step(); idle();
        chk("byp_pri0", rd_data[31:0], exp_pri_data);
        chk("byp_pri1", rd_data[63:32], exp_pri_data);

        // reset overrides a concurrent write, issue and read
        we0 = 1; wR0 = 5'd12; wD0 = 32'h77; issue_en = 1; issue_addr = 5'd12;
        rd_en = 2'b11; rd_addr = {5'd5, 5'd11}; cpu_rst = 1;
        step(); idle(); cpu_rst = 0;
        chk("mid_rst_out", rd_data[31:0] | rd_data[63:32], 32'h0);
        rd_en = 2'b11; rd_addr = {5'd5, 5'd12};
        step(); idle();
        chk("mid_rst_r12", rd_data[31:0], 32'h0);
        chk("mid_rst_r5", rd_data[63:32], 32'h0);
        chk("mid_rst_busy", {30'b0, rd_busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised successor to the single-cycle core's register file: `NUM_RD` registered read ports, two prioritised write ports, an optional hardwired-zero register and a per-register busy scoreboard. It sits between decode and writeback. Decode uses it to read operands and to mark destination registers pending. Writeback, or a second writeback/load return, uses it to commit results and clear the pending marks.

## Interface
Parameters:
- `DATA_W`, 32: register width in bits.
- `DEPTH`, 32: number of registers; power of two, ≥2. `AW = $clog2(DEPTH)`.
- `NUM_RD`, 2: number of read ports, 1–4.
- `ZERO_REG`, 1: when 1, register 0 reads as 0, ignores writes and is never busy.

Ports:
- `cpu_clk` in 1: single clock; all state updates on its rising edge.
- `cpu_rst` in 1: reset, synchronous, active-high.
- `rd_en` in NUM_RD: per-port read enable.
- `rd_addr` in NUM_RD*AW: packed read addresses; port i is at [i*AW +: AW].
- `rd_data` out NUM_RD*DATA_W: packed registered read data.
- `rd_busy` out NUM_RD: registered busy flag of the addressed register.
- `we0`, `wR0` (AW), `wD0` (DATA_W) in: write port 0, normal writeback.
- `we1`, `wR1` (AW), `wD1` (DATA_W) in: write port 1, late/load writeback.
- `issue_en` in 1: mark `issue_addr` busy.
- `issue_addr` in AW: destination register being issued.

## Operation
- On reset, all registers are cleared to 0, all busy bits to 0, and `rd_data` and `rd_busy` to 0.
- **Write:**
  - If `weN` is high, `wDN` is stored to `wRN` at the edge.
  - If both ports target the same address, port 1 wins.
  - Each write clears `busy[wRN]`.
- **Issue:**
  - `issue_en` sets `busy[issue_addr]`.
  - If an issue and a write hit the same address in the same cycle, set wins, because the new producer supersedes the old one.
- **Read:**
  - If `rd_en[i]` is high, port i captures `registers[rd_addr_i]` and `busy[rd_addr_i]` at the edge.
  - If `rd_en[i]` is low, port i holds its previous `rd_data`/`rd_busy`.
  - Ports are independent; any number may read the same address.
- **ZERO_REG=1:**
  - Writes to address 0 are dropped.
  - Issue to address 0 is ignored.
  - Reads of address 0 return 0 with busy=0, including under bypass.
- **Reset mid-operation:** `cpu_rst` overrides every write, issue and read in the same cycle.

## Timing
- Read latency is 1 cycle: the address is presented in cycle N and data is valid after edge N, in cycle N+1.
- Write latency is 1 cycle: the write is visible to a read issued in cycle N+1 without bypass.
- Busy set or clear takes effect at the edge; it is visible to reads issued in the following cycle.
- Same-cycle read and write to the same address is governed by `RF_BYPASS_EN` (see Configuration).
- Same-cycle issue and read of the same address returns the pre-issue busy value.

## Configuration
- Macro `RF_BYPASS_EN`.
- **Defined (write-first):**
  - A read in the same cycle as a write to its address returns the written data, with port 1 over port 0.
  - The captured `rd_busy` reflects that write's clear.
- **Undefined (read-first):**
  - The read returns the old register contents and the pre-write busy bit.
  - This matches the existing single-cycle core timing.

## Structure
- Package `rf_pkg` holds:
  - the `AW` derivation function;
  - default width/depth localparams;
  - a `rf_wr_t` struct (`we`, `addr`, `data`) shared with writeback.
- Sub-module `rf_scoreboard` holds the DEPTH-bit busy vector and its set/clear/priority logic, and exposes a combinational busy lookup per port.
- Register array and read/bypass muxes live in `rf_multiport`.

## Test plan
- **Reset:** hold `cpu_rst` for 2 cycles, then read addresses 0–31 on both ports → every read returns 0 with busy=0.
- **Basic write/read:** write `0xDEADBEEF` to r5 via port 0, then read r5 on port 1 next cycle → `0xDEADBEEF` one cycle later.
- **Write collision:** port 0 writes `0x11` and port 1 writes `0x22` to r7 in the same cycle → a later read of r7 returns `0x22`.
- **Zero register:** with ZERO_REG=1, write `0xFFFFFFFF` to r0 and issue r0 → reads of r0 return 0 with busy=0.
- **Scoreboard:**
  - Issue r3, then read r3 → busy=1.
  - Write r3 = `0x5`, then read → data `0x5`, busy=0.
  - Issue and write r3 in the same cycle → busy stays 1.
- **Bypass:** read r9 while writing `0xA5A5A5A5` to r9 (old value `0x1`) → `0xA5A5A5A5` with `RF_BYPASS_EN` defined, `0x1` without it.
